// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
// No logic; imported by the read port and the top.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W   = 16;
    localparam int RF_DEPTH    = 16;
    localparam int RF_NUM_READ = 2;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read path: range check, zero register, write bypass, storage mux.
// Latency: zero cycles; no backpressure, reads return 0 while the file is not ready.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                          ready_i,
    input  logic [AW-1:0]                 rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
    input  logic                          wr_acc_i,
    input  logic [AW-1:0]                 wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic [DATA_W-1:0]             rd_data_o
);

    logic in_range;
    logic is_zero_reg;
    logic hit_bypass;

    assign in_range    = 32'(rd_addr_i) < 32'(DEPTH);
    assign is_zero_reg = ZERO_REG && (rd_addr_i == '0);
    assign hit_bypass  = BYPASS && wr_acc_i && (wr_addr_i == rd_addr_i);

    // Range and zero-register checks gate the storage index, so an
    // out-of-range address never selects a non-existent entry.
    always_comb begin
        rd_data_o = '0;
        if (ready_i && in_range && !is_zero_reg) begin
            if (hit_bypass) begin
                rd_data_o = wr_data_i;
            end else begin
                rd_data_o = mem_i[rd_addr_i];
            end
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with a clear sequencer that zeroes every entry after reset or clr.
// Latency: reads combinational, writes land at the posedge; writes are refused while ready is low (DEPTH cycles per clear).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_READ = RF_NUM_READ,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [NUM_READ*AW-1:0]       rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic                         ready
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    rf_state_t                   state_q, state_d;
    logic [AW-1:0]               clr_ptr_q, clr_ptr_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    logic wr_in_range;
    logic wr_acc;

    assign ready       = (state_q == RF_READY);
    assign wr_in_range = 32'(wr_addr) < 32'(DEPTH);
    assign wr_acc      = ready && wr_en && !clr && wr_in_range
                         && !(ZERO_REG && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            RF_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = RF_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            RF_READY: begin
                if (clr) begin
                    state_d   = RF_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage carries no reset; the sequencer is the only thing that defines it.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .ready_i  (ready),
            .rd_addr_i(rd_addr[k*AW +: AW]),
            .mem_i    (mem_q),
            .wr_acc_i (wr_acc),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .rd_data_o(rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Directed bench: bypass, non-bypass and zero-register 16x16 files share stimulus,
// plus a 32-bit, 12-deep, 3-port build driven separately.
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_byp, rd_nob, rd_zr;
    logic        rdy_byp, rdy_nob, rdy_zr;

    logic        p_wr_en;
    logic [3:0]  p_wr_addr;
    logic [31:0] p_wr_data;
    logic [11:0] p_rd_addr;
    logic [95:0] p_rd_data;
    logic        rdy_par;

    int n_pass  = 0;
    int n_total = 0;

    regfile_param u_byp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_byp), .ready(rdy_byp));

    regfile_param #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_nob), .ready(rdy_nob));

    regfile_param #(.ZERO_REG(1'b1)) u_zr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_zr), .ready(rdy_zr));

    regfile_param #(.DATA_W(32), .DEPTH(12), .NUM_READ(3)) u_par (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(p_wr_en), .wr_addr(p_wr_addr),
        .wr_data(p_wr_data), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .ready(rdy_par));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] e_byp;   // {port1, port0}, sampled before the edge
        logic [31:0] e_nob;
        logic [31:0] e_zr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 4'd5,  16'h2025, 4'd5,  4'd1,  32'h0000_2025, 32'h0000_0000, 32'h0000_2025};
        vecs[1] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd1,  32'h0000_2025, 32'h0000_2025, 32'h0000_2025};
        vecs[2] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd0,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd5,  32'h2025_FFFF, 32'h2025_FFFF, 32'h2025_0000};
        vecs[4] = '{1'b1, 4'd15, 16'hA5A5, 4'd15, 4'd14, 32'h0000_A5A5, 32'h0000_0000, 32'h0000_A5A5};
        vecs[5] = '{1'b1, 4'd14, 16'h1234, 4'd15, 4'd14, 32'h1234_A5A5, 32'h0000_A5A5, 32'h1234_A5A5};
        vecs[6] = '{1'b0, 4'd0,  16'h0000, 4'd14, 4'd14, 32'h1234_1234, 32'h1234_1234, 32'h1234_1234};
        vecs[7] = '{1'b1, 4'd5,  16'h0F0F, 4'd5,  4'd0,  32'hFFFF_0F0F, 32'hFFFF_2025, 32'h0000_0F0F};
        vecs[8] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F};

        rst_n = 1'b0; clr = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0; rd_addr = {4'd3, 4'd7};
        p_wr_en = 1'b0; p_wr_addr = 4'd0; p_wr_data = 32'h0; p_rd_addr = {4'd11, 4'd14, 4'd2};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ready", 128'({rdy_byp, rdy_nob, rdy_zr, rdy_par}), 128'(0));
            chk("rst_rd16", 128'({rd_byp, rd_nob, rd_zr}), 128'(0));
            chk("rst_rd32", 128'(p_rd_data), 128'(0));
        end

        // Clear after release: 16 edges for the 16-deep files, 12 for the 12-deep one
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            chk("init_ready16", 128'({rdy_byp, rdy_nob, rdy_zr}), (i == 16) ? 128'(3'b111) : 128'(0));
            chk("init_ready12", 128'(rdy_par), 128'(i >= 12));
            if (i < 16) chk("init_rd_clear", 128'(rd_byp), 128'(0));
        end

        // Every entry reads zero after the clear
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rd_addr   = {4'(15 - a), 4'(a)};
            p_rd_addr = {4'(a), 4'(a), 4'(a)};
            #1;
            chk("sweep16", 128'({rd_byp, rd_nob, rd_zr}), 128'(0));
            chk("sweep12", 128'(p_rd_data), 128'(0));
        end

        // Table-driven write/read vectors, sampled before each accepting edge
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            chk($sformatf("vec%0d_byp", v), 128'(rd_byp), 128'(vecs[v].e_byp));
            chk($sformatf("vec%0d_nob", v), 128'(rd_nob), 128'(vecs[v].e_nob));
            chk($sformatf("vec%0d_zr",  v), 128'(rd_zr),  128'(vecs[v].e_zr));
        end
        @(negedge clk); wr_en = 1'b0;

        // Parametric build: three ports, 32-bit data, addresses 12..15 out of range
        p_wr_en = 1'b1; p_wr_addr = 4'd11; p_wr_data = 32'hDEADBEEF;
        p_rd_addr = {4'd11, 4'd11, 4'd11};
        #1;
        chk("par_bypass", 128'(p_rd_data), 128'({32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}));
        @(negedge clk);
        p_wr_addr = 4'd13; p_wr_data = 32'h12345678;
        p_rd_addr = {4'd14, 4'd13, 4'd11};
        #1;
        chk("par_oor_wr", 128'(p_rd_data), 128'({32'h0, 32'h0, 32'hDEADBEEF}));
        @(negedge clk);
        p_wr_en = 1'b0; p_rd_addr = {4'd11, 4'd11, 4'd11};
        #1;
        chk("par_stored", 128'(p_rd_data), 128'({32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}));
        @(negedge clk); p_rd_addr = {4'd13, 4'd14, 4'd11};
        #1;
        chk("par_oor_rd", 128'(p_rd_data), 128'({32'h0, 32'h0, 32'hDEADBEEF}));

        // Write versus clear: clr wins, the write in the same cycle is dropped
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h5678;
        @(negedge clk); clr = 1'b1; wr_addr = 4'd2; wr_data = 16'hBEEF; rd_addr = {4'd2, 4'd1};
        #1;
        chk("wc_pre_ready", 128'(rdy_byp), 128'(1));
        chk("wc_pre_rd", 128'(rd_byp), 128'({16'h0000, 16'h5678}));
        @(posedge clk); #1;
        chk("wc_ready_drop", 128'({rdy_byp, rdy_nob, rdy_zr, rdy_par}), 128'(0));
        clr = 1'b0; wr_addr = 4'd3; wr_data = 16'h1111;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            chk("wc_ready16", 128'(rdy_byp), 128'(i == 16));
            chk("wc_ready12", 128'(rdy_par), 128'(i >= 12));
            chk("wc_rd", 128'(rd_byp), 128'(0));
        end
        wr_en = 1'b0;
        @(negedge clk); rd_addr = {4'd3, 4'd2}; #1;
        chk("wc_after_23", 128'({rd_byp, rd_nob}), 128'(0));
        @(negedge clk); rd_addr = {4'd1, 4'd1}; #1;
        chk("wc_after_1", 128'({rd_byp, rd_nob}), 128'(0));

        // Async reset in the middle of a clear restarts the full sequence
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
        @(negedge clk); wr_en = 1'b0; clr = 1'b1; rd_addr = {4'd4, 4'd4}; #1;
        chk("ar_stored", 128'(rd_byp), 128'({16'h4444, 16'h4444}));
        @(posedge clk); #1; clr = 1'b0;
        chk("ar_clearing", 128'(rdy_byp), 128'(0));
        for (int i = 1; i <= 7; i++) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("ar_rst_ready", 128'({rdy_byp, rdy_nob, rdy_zr, rdy_par}), 128'(0));
        chk("ar_rst_rd", 128'({rd_byp, rd_nob, rd_zr}), 128'(0));
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            chk("ar_ready16", 128'(rdy_byp), 128'(i == 16));
        end
        @(negedge clk); #1;
        chk("ar_after", 128'(rd_byp), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_param
